// File: rtl/rvh_l1d_refill_victim_ctrl.sv
// L1D refill victim selector: chooses a victim way per miss (invalid way first, else PLRU),
// issues a dirty writeback when needed and owns the per-set valid/dirty arrays.
module rvh_l1d_refill_victim_ctrl #(
  parameter int entry_num   = 32,
  parameter int entry_idx   = $clog2(entry_num),
  parameter int way_num     = 4,
  parameter int way_num_idx = $clog2(way_num)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   req_vld_i,
  output logic                   req_rdy_o,
  input  logic [entry_idx-1:0]   req_set_idx_i,
  output logic                   plru_rd_en_o,
  output logic [entry_idx-1:0]   plru_rd_idx_o,
  input  logic [way_num_idx-1:0] plru_rd_way_i,
  input  logic                   st_hit_vld_i,
  input  logic [entry_idx-1:0]   st_hit_set_i,
  input  logic [way_num_idx-1:0] st_hit_way_i,
  input  logic                   inv_vld_i,
  input  logic [entry_idx-1:0]   inv_set_i,
  input  logic [way_num_idx-1:0] inv_way_i,
  output logic                   evict_vld_o,
  input  logic                   evict_rdy_i,
  output logic [entry_idx-1:0]   evict_set_o,
  output logic [way_num_idx-1:0] evict_way_o,
  output logic                   resp_vld_o,
  input  logic                   resp_rdy_i,
  output logic [entry_idx-1:0]   resp_set_o,
  output logic [way_num_idx-1:0] resp_way_o,
  output logic                   lock_vld_o,
  output logic [entry_idx-1:0]   lock_set_o,
  output logic [way_num_idx-1:0] lock_way_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_EVICT  = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  state_e                               r_state;
  state_e                               w_state_nxt;
  logic [entry_idx-1:0]                 r_set;
  logic [way_num_idx-1:0]               r_way;
  logic [entry_num-1:0][way_num-1:0]    r_valid;
  logic [entry_num-1:0][way_num-1:0]    r_dirty;
  logic [entry_num-1:0][way_num-1:0]    w_valid_nxt;
  logic [entry_num-1:0][way_num-1:0]    w_dirty_nxt;
  logic [way_num-1:0]                   w_lookup_valid;
  logic [way_num-1:0]                   w_lookup_dirty;
  logic                                 w_has_inv;
  logic [way_num_idx-1:0]               w_inv_way;
  logic [way_num_idx-1:0]               w_victim;
  logic                                 w_vdirty;
  logic                                 w_accept;
  logic                                 w_refill_done;

  assign w_accept      = (r_state == ST_IDLE) && req_vld_i;
  assign w_refill_done = (r_state == ST_RESP) && resp_rdy_i;

  // Victim choice on the captured set, using the arrays as they stand at the start of the cycle
  always_comb begin
    w_lookup_valid = r_valid[r_set];
    w_lookup_dirty = r_dirty[r_set];
    w_has_inv      = ~(&w_lookup_valid);
    w_inv_way      = '0;
    for (int i = way_num - 1; i >= 0; i--) begin
      w_inv_way = (!w_lookup_valid[i]) ? way_num_idx'(i) : w_inv_way;
    end
    if (w_has_inv) begin
      w_victim = w_inv_way;
    end else begin
      w_victim = plru_rd_way_i;
    end
    w_vdirty = w_lookup_valid[w_victim] & w_lookup_dirty[w_victim];
  end

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   w_state_nxt = req_vld_i ? ST_LOOKUP : ST_IDLE;
      ST_LOOKUP: w_state_nxt = w_vdirty ? ST_EVICT : ST_RESP;
      ST_EVICT:  w_state_nxt = evict_rdy_i ? ST_RESP : ST_EVICT;
      ST_RESP:   w_state_nxt = resp_rdy_i ? ST_IDLE : ST_RESP;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Captured set on accept and victim way at the end of lookup
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_set <= '0;
      r_way <= '0;
    end else begin
      if (w_accept) begin
        r_set <= req_set_idx_i;
      end else begin
        r_set <= r_set;
      end
      if (r_state == ST_LOOKUP) begin
        r_way <= w_victim;
      end else begin
        r_way <= r_way;
      end
    end
  end

  // Array updates: refill completion, then store hit, then invalidate (later step wins)
  always_comb begin
    w_valid_nxt = r_valid;
    w_dirty_nxt = r_dirty;
    if (w_refill_done) begin
      w_valid_nxt[r_set][r_way] = 1'b1;
      w_dirty_nxt[r_set][r_way] = 1'b0;
    end else begin
      w_valid_nxt = w_valid_nxt;
    end
    if (st_hit_vld_i && w_valid_nxt[st_hit_set_i][st_hit_way_i]) begin
      w_dirty_nxt[st_hit_set_i][st_hit_way_i] = 1'b1;
    end else begin
      w_dirty_nxt = w_dirty_nxt;
    end
    if (inv_vld_i) begin
      w_valid_nxt[inv_set_i][inv_way_i] = 1'b0;
      w_dirty_nxt[inv_set_i][inv_way_i] = 1'b0;
    end else begin
      w_valid_nxt = w_valid_nxt;
    end
  end

  // Valid and dirty arrays
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else begin
      r_valid <= w_valid_nxt;
      r_dirty <= w_dirty_nxt;
    end
  end

  assign req_rdy_o     = (r_state == ST_IDLE);
  assign plru_rd_en_o  = (r_state == ST_LOOKUP) && !w_has_inv;
  assign plru_rd_idx_o = r_set;
  assign evict_vld_o   = (r_state == ST_EVICT);
  assign evict_set_o   = r_set;
  assign evict_way_o   = r_way;
  assign resp_vld_o    = (r_state == ST_RESP);
  assign resp_set_o    = r_set;
  assign resp_way_o    = r_way;
  // The line stays locked from the eviction until the refill completes
  assign lock_vld_o    = (r_state == ST_EVICT) || (r_state == ST_RESP);
  assign lock_set_o    = r_set;
  assign lock_way_o    = r_way;

endmodule

// File: tb/tb_rvh_l1d_refill_victim_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic against a transaction-level
// reference model of the victim selector and its valid/dirty arrays.
module tb_rvh_l1d_refill_victim_ctrl;
  localparam int EN = 32;
  localparam int WN = 4;
  localparam int EI = 5;
  localparam int WI = 2;

  logic          clk = 1'b0;
  logic          rstn;
  logic          req_vld_i, req_rdy_o;
  logic [EI-1:0] req_set_idx_i;
  logic          plru_rd_en_o;
  logic [EI-1:0] plru_rd_idx_o;
  logic [WI-1:0] plru_rd_way_i;
  logic          st_hit_vld_i;
  logic [EI-1:0] st_hit_set_i;
  logic [WI-1:0] st_hit_way_i;
  logic          inv_vld_i;
  logic [EI-1:0] inv_set_i;
  logic [WI-1:0] inv_way_i;
  logic          evict_vld_o, evict_rdy_i;
  logic [EI-1:0] evict_set_o;
  logic [WI-1:0] evict_way_o;
  logic          resp_vld_o, resp_rdy_i;
  logic [EI-1:0] resp_set_o;
  logic [WI-1:0] resp_way_o;
  logic          lock_vld_o;
  logic [EI-1:0] lock_set_o;
  logic [WI-1:0] lock_way_o;

  rvh_l1d_refill_victim_ctrl #(.entry_num(EN), .way_num(WN)) u_dut (
    .clk(clk), .rstn(rstn),
    .req_vld_i(req_vld_i), .req_rdy_o(req_rdy_o), .req_set_idx_i(req_set_idx_i),
    .plru_rd_en_o(plru_rd_en_o), .plru_rd_idx_o(plru_rd_idx_o), .plru_rd_way_i(plru_rd_way_i),
    .st_hit_vld_i(st_hit_vld_i), .st_hit_set_i(st_hit_set_i), .st_hit_way_i(st_hit_way_i),
    .inv_vld_i(inv_vld_i), .inv_set_i(inv_set_i), .inv_way_i(inv_way_i),
    .evict_vld_o(evict_vld_o), .evict_rdy_i(evict_rdy_i),
    .evict_set_o(evict_set_o), .evict_way_o(evict_way_o),
    .resp_vld_o(resp_vld_o), .resp_rdy_i(resp_rdy_i),
    .resp_set_o(resp_set_o), .resp_way_o(resp_way_o),
    .lock_vld_o(lock_vld_o), .lock_set_o(lock_set_o), .lock_way_o(lock_way_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: cache arrays plus one in-flight miss transaction
  bit m_valid [EN][WN];
  bit m_dirty [EN][WN];
  bit m_busy, m_lookup, m_ev, m_rs;
  int m_set, m_way;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int lowest_invalid(input int s);
    for (int w = 0; w < WN; w++) if (!m_valid[s][w]) return w;
    return -1;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < EN; s++)
      for (int w = 0; w < WN; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
      end
    m_busy = 0; m_lookup = 0; m_ev = 0; m_rs = 0; m_set = 0; m_way = 0;
  endtask

  task automatic clear_inputs();
    req_vld_i = 0; req_set_idx_i = '0; plru_rd_way_i = '0;
    st_hit_vld_i = 0; st_hit_set_i = '0; st_hit_way_i = '0;
    inv_vld_i = 0; inv_set_i = '0; inv_way_i = '0;
    evict_rdy_i = 0; resp_rdy_i = 0;
  endtask

  task automatic check_outputs();
    check_eq("req_rdy", req_rdy_o, !m_busy);
    check_eq("plru_en", plru_rd_en_o, m_lookup && (lowest_invalid(m_set) < 0));
    check_eq("plru_idx", plru_rd_idx_o, m_set);
    check_eq("evict_vld", evict_vld_o, m_ev);
    check_eq("resp_vld", resp_vld_o, m_rs);
    check_eq("lock_vld", lock_vld_o, m_ev || m_rs);
    check_eq("evict_set", evict_set_o, m_set);
    check_eq("evict_way", evict_way_o, m_way);
    check_eq("resp_set", resp_set_o, m_set);
    check_eq("resp_way", resp_way_o, m_way);
    check_eq("lock_set", lock_set_o, m_set);
    check_eq("lock_way", lock_way_o, m_way);
  endtask

  // One clock: compare outputs mid-cycle, advance the model with this cycle's inputs
  task automatic cycle();
    bit refill;
    int v;
    @(negedge clk);
    check_outputs();
    refill = 0;
    if (m_lookup) begin
      v = lowest_invalid(m_set);
      if (v < 0) v = int'(plru_rd_way_i);
      m_way = v;
      m_lookup = 0;
      if (m_valid[m_set][v] && m_dirty[m_set][v]) m_ev = 1;
      else m_rs = 1;
    end else if (m_ev) begin
      if (evict_rdy_i) begin m_ev = 0; m_rs = 1; end
    end else if (m_rs) begin
      if (resp_rdy_i) begin m_rs = 0; m_busy = 0; refill = 1; end
    end else if (!m_busy && req_vld_i) begin
      m_busy = 1; m_lookup = 1; m_set = int'(req_set_idx_i);
    end
    if (refill) begin
      m_valid[m_set][m_way] = 1'b1;
      m_dirty[m_set][m_way] = 1'b0;
    end
    if (st_hit_vld_i && m_valid[st_hit_set_i][st_hit_way_i]) m_dirty[st_hit_set_i][st_hit_way_i] = 1'b1;
    if (inv_vld_i) begin
      m_valid[inv_set_i][inv_way_i] = 1'b0;
      m_dirty[inv_set_i][inv_way_i] = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  // Full miss transaction; reports chosen way, eviction cycles, PLRU reads and accept->resp latency
  task automatic do_req(input int s, input int pw, input int ev_wait, input int rs_wait,
                        output int way, output int ev_cycles, output int plru_cycles, output int lat);
    int n;
    ev_cycles = 0; plru_cycles = 0;
    req_vld_i = 1; req_set_idx_i = EI'(s); plru_rd_way_i = WI'(pw);
    evict_rdy_i = 0; resp_rdy_i = 0;
    n = 0;
    while (!req_rdy_o && n < 50) begin cycle(); n++; end
    cycle();
    req_vld_i = 0;
    lat = 1;
    while (!resp_vld_o && lat < 100) begin
      if (plru_rd_en_o) plru_cycles++;
      if (evict_vld_o) begin
        ev_cycles++;
        evict_rdy_i = (ev_cycles > ev_wait);
      end
      cycle();
      lat++;
    end
    evict_rdy_i = 0;
    check_eq("resp_timeout", resp_vld_o, 1);
    way = int'(resp_way_o);
    for (int i = 0; i < rs_wait; i++) begin
      cycle();
      check_eq("hold_req_rdy", req_rdy_o, 0);
      check_eq("hold_lock", lock_vld_o, 1);
      check_eq("hold_way", resp_way_o, way);
      check_eq("hold_set", resp_set_o, s);
    end
    resp_rdy_i = 1;
    cycle();
    resp_rdy_i = 0;
  endtask

  int way, evc, plc, lat;

  initial begin
    clear_inputs();
    model_reset();
    rstn = 0;
    #12;
    check_eq("rst_req_rdy", req_rdy_o, 1);
    check_eq("rst_plru_en", plru_rd_en_o, 0);
    check_eq("rst_evict", evict_vld_o, 0);
    check_eq("rst_resp", resp_vld_o, 0);
    check_eq("rst_lock", lock_vld_o, 0);
    check_eq("rst_way", resp_way_o, 0);
    @(posedge clk); #1;
    rstn = 1;

    // Empty cache: way 0, no PLRU read, response two cycles after accept
    do_req(5, 3, 0, 0, way, evc, plc, lat);
    check_eq("t1_way", way, 0);
    check_eq("t1_plru", plc, 0);
    check_eq("t1_lat", lat, 2);
    do_req(5, 3, 0, 0, way, evc, plc, lat);
    check_eq("t1_next_way", way, 1);

    // Fill set 3, then a full-set miss reads the PLRU once
    for (int i = 0; i < WN; i++) begin
      do_req(3, 0, 0, 0, way, evc, plc, lat);
      check_eq("t2_fill_way", way, i);
    end
    do_req(3, 2, 0, 0, way, evc, plc, lat);
    check_eq("t2_way", way, 2);
    check_eq("t2_plru", plc, 1);
    check_eq("t2_evict", evc, 0);

    // Dirty victim: eviction held while evict_rdy is low
    st_hit_vld_i = 1; st_hit_set_i = 5'd3; st_hit_way_i = 2'd1;
    cycle();
    st_hit_vld_i = 0;
    do_req(3, 1, 4, 0, way, evc, plc, lat);
    check_eq("t3_way", way, 1);
    check_eq("t3_evict_cycles", evc, 5);
    check_eq("t3_lat", lat, 7);
    do_req(3, 1, 0, 0, way, evc, plc, lat);
    check_eq("t3_clean_after", evc, 0);

    // Invalidate in a full set makes that way the victim without a PLRU read
    for (int i = 0; i < WN; i++) do_req(7, 0, 0, 0, way, evc, plc, lat);
    inv_vld_i = 1; inv_set_i = 5'd7; inv_way_i = 2'd2;
    cycle();
    inv_vld_i = 0;
    do_req(7, 0, 0, 0, way, evc, plc, lat);
    check_eq("t4_way", way, 2);
    check_eq("t4_plru", plc, 0);

    // Response back-pressure for 10 cycles
    do_req(9, 0, 0, 10, way, evc, plc, lat);
    check_eq("t5_way", way, 0);

    // Async reset during an eviction
    st_hit_vld_i = 1; st_hit_set_i = 5'd3; st_hit_way_i = 2'd0;
    cycle();
    st_hit_vld_i = 0;
    req_vld_i = 1; req_set_idx_i = 5'd3; plru_rd_way_i = 2'd0;
    cycle();
    req_vld_i = 0;
    for (int i = 0; i < 4 && !evict_vld_o; i++) cycle();
    check_eq("t6_in_evict", evict_vld_o, 1);
    #2;
    rstn = 0;
    #1;
    check_eq("t6_req_rdy", req_rdy_o, 1);
    check_eq("t6_evict", evict_vld_o, 0);
    check_eq("t6_lock", lock_vld_o, 0);
    check_eq("t6_evict_way", evict_way_o, 0);
    check_eq("t6_set", lock_set_o, 0);
    model_reset();
    clear_inputs();
    @(posedge clk); #1;
    rstn = 1;
    do_req(3, 3, 0, 0, way, evc, plc, lat);
    check_eq("t6_way", way, 0);
    check_eq("t6_plru", plc, 0);

    // Random traffic on a few sets so they fill, evict and get hit/invalidated
    for (int c = 0; c < 4000; c++) begin
      req_vld_i     = ($urandom_range(0, 1) == 1);
      req_set_idx_i = EI'($urandom_range(0, 5));
      plru_rd_way_i = WI'($urandom_range(0, WN - 1));
      st_hit_vld_i  = ($urandom_range(0, 9) < 4);
      st_hit_set_i  = EI'($urandom_range(0, 5));
      st_hit_way_i  = WI'($urandom_range(0, WN - 1));
      inv_vld_i     = ($urandom_range(0, 9) == 0);
      inv_set_i     = EI'($urandom_range(0, 5));
      inv_way_i     = WI'($urandom_range(0, WN - 1));
      evict_rdy_i   = ($urandom_range(0, 2) != 0);
      resp_rdy_i    = ($urandom_range(0, 2) != 0);
      cycle();
    end
    clear_inputs();
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
